// File: rtl/core_dispatcher_in_if.sv
// core_dispatcher_in_if: FPGA-side stream, per-core output lanes and dispatch status
interface core_dispatcher_in_if #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32
);
  logic                          s_valid;
  logic                          s_ready;
  logic                          s_last;
  logic [DATA_WIDTH-1:0]         s_data;
  logic [M_COUNT-1:0]            access_core_in;
  logic [M_COUNT-1:0]            m_valid;
  logic [M_COUNT-1:0]            m_ready;
  logic [M_COUNT-1:0]            m_last;
  logic [M_COUNT*DATA_WIDTH-1:0] m_data;
  logic                          active;
  logic [$clog2(M_COUNT)-1:0]    cur_core;
  modport slave (
    input  s_valid, s_last, s_data, access_core_in, m_ready,
    output s_ready, m_valid, m_last, m_data, active, cur_core
  );
  modport master (
    output s_valid, s_last, s_data, access_core_in, m_ready,
    input  s_ready, m_valid, m_last, m_data, active, cur_core
  );
endinterface

// File: rtl/core_dispatcher_in.sv
// core_dispatcher_in: buffers the inbound FPGA stream and dispatches whole frames round-robin to enabled cores
module core_dispatcher_in #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 resetb,
  core_dispatcher_in_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(M_COUNT);
  typedef enum logic {IDLE, SEND} state_t;
  logic [DATA_WIDTH:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [AW:0]                   count, count_next;
  logic                          ready, push, pop, empty, found, active;
  logic [DATA_WIDTH:0]           head;
  state_t                        state;
  logic [CW-1:0]                 cur_core, rr_ptr, sel;
  logic [M_COUNT-1:0]            m_valid, m_last;
  logic [M_COUNT*DATA_WIDTH-1:0] m_data;
  int                            idx;
  assign empty      = count == '0;
  assign head       = mem[rd_ptr];
  assign push       = bus.s_valid && ready;
  assign pop        = state == SEND && !empty && bus.m_ready[cur_core];
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  // Storage only; entries beyond the count are never observed, so no reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.s_last, bus.s_data};
  // Pointers and count; ready is registered from the next count so a full FIFO stays closed even while popping
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= count_next != (AW+1)'(FIFO_DEPTH);
    end
  // First enabled core at or after rr_ptr, wrapping; lowest offset wins
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = M_COUNT - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      idx = idx >= M_COUNT ? idx - M_COUNT : idx;
      if (bus.access_core_in[CW'(idx)]) begin
        sel   = CW'(idx);
        found = 1'b1;
      end
    end
  end
  // Dispatcher: lock a frame to a core in IDLE, release it after the last beat pops
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cur_core <= '0;
      active   <= 1'b0;
    end else if (state == IDLE) begin
      if (found && !empty) begin
        cur_core <= sel;
        state    <= SEND;
        active   <= 1'b1;
      end
    end else if (pop && head[DATA_WIDTH]) begin
      state  <= IDLE;
      active <= 1'b0;
      rr_ptr <= cur_core == CW'(M_COUNT - 1) ? '0 : cur_core + 1'b1;
    end
  // Only the locked core's lane is driven; every other lane reads zero
  always_comb begin
    m_valid = '0;
    m_last  = '0;
    m_data  = '0;
    if (state == SEND && !empty) begin
      m_valid[cur_core]                         = 1'b1;
      m_last[cur_core]                          = head[DATA_WIDTH];
      m_data[cur_core*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
    end
  end
  assign bus.s_ready  = ready;
  assign bus.m_valid  = m_valid;
  assign bus.m_last   = m_last;
  assign bus.m_data   = m_data;
  assign bus.active   = active;
  assign bus.cur_core = cur_core;
endmodule

// File: tb/tb_core_dispatcher_in.sv
// tb_core_dispatcher_in: table-driven per-cycle vectors plus reset sequences for core_dispatcher_in
module tb_core_dispatcher_in;
  localparam int M  = 4;
  localparam int DW = 32;
  logic clk    = 1'b0;
  logic resetb = 1'b1;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  core_dispatcher_in_if #(.M_COUNT(M), .DATA_WIDTH(DW)) bus ();
  core_dispatcher_in #(.M_COUNT(M), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .resetb(resetb),
    .bus(bus)
  );
  typedef struct {
    int          sc;
    logic        sv, sl;
    logic [DW-1:0] sd;
    logic [M-1:0] acc, mr;
    logic        rdy;
    logic [M-1:0] mv, ml;
    logic [DW-1:0] dat;
    logic        act;
    logic [1:0]  cur;
  } vec_t;
  vec_t vecs[$];
  function automatic void v(int sc, logic sv, logic sl, logic [DW-1:0] sd, logic [M-1:0] acc,
                            logic [M-1:0] mr, logic rdy, logic [M-1:0] mv, logic [M-1:0] ml,
                            logic [DW-1:0] dat, logic act, logic [1:0] cur);
    vec_t t;
    t.sc = sc; t.sv = sv; t.sl = sl; t.sd = sd; t.acc = acc; t.mr = mr;
    t.rdy = rdy; t.mv = mv; t.ml = ml; t.dat = dat; t.act = act; t.cur = cur;
    vecs.push_back(t);
  endfunction
  task automatic check(string name, logic [159:0] got, logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
    bus.access_core_in = '0; bus.m_ready = '0;
  endtask
  task automatic do_reset(string tag);
    idle_inputs();
    resetb = 1'b0;
    #2;
    check({tag, "_outs_zero"}, {bus.m_valid, bus.m_last, bus.m_data, bus.active, bus.cur_core}, '0);
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    #1 check({tag, "_ready_low"}, {159'd0, bus.s_ready}, 160'd0);
    @(posedge clk);
    #1 check({tag, "_ready_high"}, {159'd0, bus.s_ready}, 160'd1);
  endtask
  task automatic run_sc(int sc);
    int row = 0;
    logic [M*DW-1:0] ed;
    foreach (vecs[i]) if (vecs[i].sc == sc) begin
      bus.s_valid = vecs[i].sv; bus.s_last = vecs[i].sl; bus.s_data = vecs[i].sd;
      bus.access_core_in = vecs[i].acc; bus.m_ready = vecs[i].mr;
      @(negedge clk);
      ed = '0;
      for (int j = 0; j < M; j++) if (vecs[i].mv[j]) ed[j*DW +: DW] = vecs[i].dat;
      check($sformatf("sc%0d_row%0d", sc, row),
            {20'd0, bus.s_ready, bus.m_valid, bus.m_last, bus.m_data, bus.active, bus.cur_core},
            {20'd0, vecs[i].rdy, vecs[i].mv, vecs[i].ml, ed, vecs[i].act, vecs[i].cur});
      row++;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    // 1: three 2-beat frames, all cores enabled -> cores 0,1,2
    v(1,1,0,'hA0,4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(1,1,1,'hA1,4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(1,1,0,'hB0,4'hF,4'hF, 1,4'h1,4'h0,'hA0, 1,0);
    v(1,1,1,'hB1,4'hF,4'hF, 1,4'h1,4'h1,'hA1, 1,0);
    v(1,1,0,'hC0,4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(1,1,1,'hC1,4'hF,4'hF, 1,4'h2,4'h0,'hB0, 1,1);
    v(1,0,0,0,   4'hF,4'hF, 1,4'h2,4'h2,'hB1, 1,1);
    v(1,0,0,0,   4'hF,4'hF, 1,4'h0,4'h0,0,    0,1);
    v(1,0,0,0,   4'hF,4'hF, 1,4'h4,4'h0,'hC0, 1,2);
    v(1,0,0,0,   4'hF,4'hF, 1,4'h4,4'h4,'hC1, 1,2);
    v(1,0,0,0,   4'hF,4'hF, 1,4'h0,4'h0,0,    0,2);
    // 2: mask 1010, single-beat frames -> cores 1,3,1,3
    v(2,1,1,'h1,4'hA,4'hF, 1,4'h0,4'h0,0,   0,0);
    v(2,1,1,'h2,4'hA,4'hF, 1,4'h0,4'h0,0,   0,0);
    v(2,1,1,'h3,4'hA,4'hF, 1,4'h2,4'h2,'h1, 1,1);
    v(2,1,1,'h4,4'hA,4'hF, 1,4'h0,4'h0,0,   0,1);
    v(2,0,0,0,  4'hA,4'hF, 1,4'h8,4'h8,'h2, 1,3);
    v(2,0,0,0,  4'hA,4'hF, 1,4'h0,4'h0,0,   0,3);
    v(2,0,0,0,  4'hA,4'hF, 1,4'h2,4'h2,'h3, 1,1);
    v(2,0,0,0,  4'hA,4'hF, 1,4'h0,4'h0,0,   0,1);
    v(2,0,0,0,  4'hA,4'hF, 1,4'h8,4'h8,'h4, 1,3);
    v(2,0,0,0,  4'hA,4'hF, 1,4'h0,4'h0,0,   0,3);
    // 3: no core enabled -> FIFO fills and back-pressures, then core 0 drains it
    v(3,1,0,'h10,4'h0,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(3,1,0,'h11,4'h0,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(3,1,0,'h12,4'h0,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(3,1,1,'h13,4'h0,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(3,1,1,'h14,4'h0,4'hF, 0,4'h0,4'h0,0,    0,0);
    v(3,1,1,'h14,4'h1,4'hF, 0,4'h0,4'h0,0,    0,0);
    v(3,0,0,0,   4'h1,4'hF, 0,4'h1,4'h0,'h10, 1,0);
    v(3,0,0,0,   4'h1,4'hF, 1,4'h1,4'h0,'h11, 1,0);
    v(3,0,0,0,   4'h1,4'hF, 1,4'h1,4'h0,'h12, 1,0);
    v(3,0,0,0,   4'h1,4'hF, 1,4'h1,4'h1,'h13, 1,0);
    v(3,0,0,0,   4'h1,4'hF, 1,4'h0,4'h0,0,    0,0);
    // 4: core 2 stalled 5 cycles, mask changed mid-frame; next frame to core 0
    v(4,1,0,'h20,4'h4,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(4,1,0,'h21,4'h4,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(4,1,1,'h22,4'h4,4'hF, 1,4'h4,4'h0,'h20, 1,2);
    v(4,1,1,'h30,4'h1,4'hB, 1,4'h4,4'h0,'h21, 1,2);
    v(4,0,0,0,   4'h1,4'hB, 1,4'h4,4'h0,'h21, 1,2);
    v(4,0,0,0,   4'h1,4'hB, 1,4'h4,4'h0,'h21, 1,2);
    v(4,0,0,0,   4'h1,4'hB, 1,4'h4,4'h0,'h21, 1,2);
    v(4,0,0,0,   4'h1,4'hB, 1,4'h4,4'h0,'h21, 1,2);
    v(4,0,0,0,   4'h1,4'hF, 1,4'h4,4'h0,'h21, 1,2);
    v(4,0,0,0,   4'h1,4'hF, 1,4'h4,4'h4,'h22, 1,2);
    v(4,0,0,0,   4'h1,4'hF, 1,4'h0,4'h0,0,    0,2);
    v(4,0,0,0,   4'h1,4'hF, 1,4'h1,4'h1,'h30, 1,0);
    v(4,0,0,0,   4'h1,4'hF, 1,4'h0,4'h0,0,    0,0);
    // 5: three beats buffered behind a stalled core 1, then reset
    v(5,1,0,'h40,4'hF,4'h0, 1,4'h0,4'h0,0,    0,0);
    v(5,1,0,'h41,4'hF,4'h0, 1,4'h0,4'h0,0,    0,0);
    v(5,1,0,'h42,4'hF,4'h0, 1,4'h2,4'h0,'h40, 1,1);
    // 6: after reset the stale beats are gone and core 0 gets the next frame
    v(6,1,1,'h50,4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(6,0,0,0,   4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(6,0,0,0,   4'hF,4'hF, 1,4'h1,4'h1,'h50, 1,0);
    v(6,0,0,0,   4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    // 7: sustained 8-beat frame then a 2-beat frame, one bubble between
    v(7,1,0,'h60,4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(7,1,0,'h61,4'hF,4'hF, 1,4'h0,4'h0,0,    0,0);
    v(7,1,0,'h62,4'hF,4'hF, 1,4'h2,4'h0,'h60, 1,1);
    v(7,1,0,'h63,4'hF,4'hF, 1,4'h2,4'h0,'h61, 1,1);
    v(7,1,0,'h64,4'hF,4'hF, 1,4'h2,4'h0,'h62, 1,1);
    v(7,1,0,'h65,4'hF,4'hF, 1,4'h2,4'h0,'h63, 1,1);
    v(7,1,0,'h66,4'hF,4'hF, 1,4'h2,4'h0,'h64, 1,1);
    v(7,1,1,'h67,4'hF,4'hF, 1,4'h2,4'h0,'h65, 1,1);
    v(7,1,0,'h70,4'hF,4'hF, 1,4'h2,4'h0,'h66, 1,1);
    v(7,1,1,'h71,4'hF,4'hF, 1,4'h2,4'h2,'h67, 1,1);
    v(7,0,0,0,   4'hF,4'hF, 1,4'h0,4'h0,0,    0,1);
    v(7,0,0,0,   4'hF,4'hF, 1,4'h4,4'h0,'h70, 1,2);
    v(7,0,0,0,   4'hF,4'hF, 1,4'h4,4'h4,'h71, 1,2);
    v(7,0,0,0,   4'hF,4'hF, 1,4'h0,4'h0,0,    0,2);
    idle_inputs();
    #1;
    do_reset("rst_a");
    run_sc(1);
    do_reset("rst_b");
    run_sc(2);
    do_reset("rst_c");
    run_sc(3);
    do_reset("rst_d");
    run_sc(4);
    run_sc(5);
    do_reset("rst_mid");
    run_sc(6);
    run_sc(7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
